// File: rtl/spi_bus_monitor.sv
// SPI mode-0 slave debug monitor: snapshots {OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN} on select and shifts it out LSB first.
// Optional trailing CRC-8 (poly 0x07) enabled by defining SPI_MONITOR_CRC8_EN.
module spi_bus_monitor #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned OSIG_W      = 8,
    parameter int unsigned ISIG_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK_IN,
    input  logic              RESET_IN,
    input  logic              SPICLK_IN,
    input  logic              SPISI_IN,
    input  logic              SPISS_IN,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [OSIG_W-1:0] OUTPUT_SIGNAL_IN,
    output logic [ISIG_W-1:0] INPUT_SIGNAL,
    output logic              INPUT_STROBE,
    output logic              SPISO,
    output logic              SPISO_OE,
    output logic              FRAME_ABORT
);
    localparam int unsigned FRAME_W = ADDR_W + DATA_W + OSIG_W;
`ifdef SPI_MONITOR_CRC8_EN
    localparam int unsigned TX_BITS = FRAME_W + 8;
`else
    localparam int unsigned TX_BITS = FRAME_W;
`endif
    localparam int unsigned CNT_W = $clog2(TX_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_OVERRUN} state_t;

    state_t                   r_state, w_next;
    logic [SYNC_STAGES-1:0]   r_sck_sync, r_ss_sync, r_si_sync;
    logic                     r_sck_prev, r_ss_prev;
    logic [TX_BITS-1:0]       r_tx;
    logic [ISIG_W-1:0]        r_rx, r_isig;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_spiso, r_oe, r_commit, r_abort, r_strobe, r_abort_o;
    logic                     w_sck, w_ss, w_si, w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;
    logic                     w_load, w_tx_shift, w_rx_shift, w_cnt_inc, w_commit, w_abort, w_rx_full;
    logic [FRAME_W-1:0]       w_frame;
    logic [TX_BITS-1:0]       w_snapshot;

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_si       = r_si_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_ss_rise  = w_ss & ~r_ss_prev;
    assign w_ss_fall  = ~w_ss & r_ss_prev;
    assign w_rx_full  = (r_cnt >= CNT_W'(ISIG_W));
    assign w_frame    = {OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN};

`ifdef SPI_MONITOR_CRC8_EN
    function automatic logic [7:0] crc8(input logic [FRAME_W-1:0] word);
        logic [7:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < FRAME_W; i++) begin
            fb = c[7] ^ word[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
    assign w_snapshot = {crc8(w_frame), w_frame};
`else
    assign w_snapshot = w_frame;
`endif

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Leaving SHIFT waits for the SCK fall after the last bit so the final MISO bit keeps its full high phase.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_ss_fall) w_next = S_SHIFT;
            S_SHIFT:   if (w_ss_rise) w_next = S_IDLE;
                       else if (w_sck_fall && r_cnt == CNT_W'(TX_BITS)) w_next = S_OVERRUN;
            S_OVERRUN: if (w_ss_rise) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_tx_shift = 1'b0;
        w_rx_shift = 1'b0;
        w_cnt_inc  = 1'b0;
        w_commit   = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            S_IDLE: w_load = w_ss_fall;
            S_SHIFT: begin
                if (w_ss_rise) begin
                    w_commit = w_rx_full;
                    w_abort  = ~w_rx_full;
                end else begin
                    w_cnt_inc  = w_sck_rise && (r_cnt != CNT_W'(TX_BITS));
                    w_rx_shift = w_sck_rise && !w_rx_full;
                    w_tx_shift = w_sck_fall;
                end
            end
            S_OVERRUN: begin
                w_commit = w_ss_rise & w_rx_full;
                w_abort  = w_ss_rise & ~w_rx_full;
            end
            default: ;
        endcase
    end

    // SS synchronisers reset low so a select held across reset is not seen as a fresh frame.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            r_sck_sync <= '0;
            r_ss_sync  <= '0;
            r_si_sync  <= '0;
            r_sck_prev <= 1'b0;
            r_ss_prev  <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cnt      <= '0;
            r_spiso    <= 1'b0;
            r_oe       <= 1'b0;
            r_commit   <= 1'b0;
            r_abort    <= 1'b0;
            r_isig     <= '0;
            r_strobe   <= 1'b0;
            r_abort_o  <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], SPICLK_IN};
            r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], SPISS_IN};
            r_si_sync  <= {r_si_sync[SYNC_STAGES-2:0], SPISI_IN};
            r_sck_prev <= w_sck;
            r_ss_prev  <= w_ss;
            if (w_load) begin
                r_tx  <= w_snapshot;
                r_cnt <= '0;
            end else begin
                if (w_tx_shift) r_tx <= {1'b0, r_tx[TX_BITS-1:1]};
                if (w_cnt_inc)  r_cnt <= r_cnt + 1'b1;
            end
            if (w_rx_shift) r_rx <= {w_si, r_rx[ISIG_W-1:1]};
            r_spiso   <= (r_state == S_SHIFT) & r_tx[0];
            r_oe      <= (r_state != S_IDLE);
            r_commit  <= w_commit;
            r_abort   <= w_abort;
            if (r_commit) r_isig <= r_rx;
            r_strobe  <= r_commit;
            r_abort_o <= r_abort;
        end
    end

    assign INPUT_SIGNAL = r_isig;
    assign INPUT_STROBE = r_strobe;
    assign SPISO        = r_spiso;
    assign SPISO_OE     = r_oe;
    assign FRAME_ABORT  = r_abort_o;
endmodule

// File: tb/tb_spi_bus_monitor.sv
// Randomised self-checking bench for spi_bus_monitor; host model drives SPI mode 0 at CLK_IN/8.
// Expected MISO/INPUT_SIGNAL come from a frame-level model (CRC via polynomial division when SPI_MONITOR_CRC8_EN).
module tb_spi_bus_monitor;
    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned OSIG_W  = 8;
    localparam int unsigned ISIG_W  = 8;
    localparam int unsigned FRAME_W = ADDR_W + DATA_W + OSIG_W;
`ifdef SPI_MONITOR_CRC8_EN
    localparam int unsigned TX_BITS = FRAME_W + 8;
`else
    localparam int unsigned TX_BITS = FRAME_W;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sck = 1'b0;
    logic              si  = 1'b0;
    logic              ss  = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] data = '0;
    logic [OSIG_W-1:0] osig = '0;
    logic [ISIG_W-1:0] isig;
    logic              strobe, miso, oe, abort_p;

    int checks = 0;
    int errors = 0;
    logic [ISIG_W-1:0] model_isig = '0;

    spi_bus_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OSIG_W(OSIG_W), .ISIG_W(ISIG_W), .SYNC_STAGES(2)) dut (
        .CLK_IN(clk), .RESET_IN(rst), .SPICLK_IN(sck), .SPISI_IN(si), .SPISS_IN(ss),
        .ADDR_IN(addr), .DATA_IN(data), .OUTPUT_SIGNAL_IN(osig),
        .INPUT_SIGNAL(isig), .INPUT_STROBE(strobe), .SPISO(miso), .SPISO_OE(oe), .FRAME_ABORT(abort_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC as remainder of (message * x^8) mod (x^8+x^2+x+1), first transmitted bit = highest degree.
    function automatic logic [7:0] model_crc(input logic [127:0] frame);
        logic [135:0] r;
        r = '0;
        for (int i = 0; i < int'(FRAME_W); i++) r[FRAME_W + 7 - i] = frame[i];
        for (int k = int'(FRAME_W) + 7; k >= 8; k--)
            if (r[k]) r[k -: 9] = r[k -: 9] ^ 9'h107;
        return r[7:0];
    endfunction

    function automatic logic [127:0] model_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                                input logic [OSIG_W-1:0] o);
        logic [127:0] w;
        w = '0;
        w[FRAME_W-1:0] = {o, d, a};
`ifdef SPI_MONITOR_CRC8_EN
        w[FRAME_W +: 8] = model_crc(w);
`endif
        return w;
    endfunction

    task automatic sck_cycle(input logic mosi, output logic sampled);
        si = mosi;
        @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sampled = miso;
        sck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [OSIG_W-1:0] o, input logic [ISIG_W-1:0] mosi, input int n,
                             input int change_at, input logic [ADDR_W-1:0] late_addr);
        logic [127:0] bits, exp_bits, word;
        logic         m, oe_during;
        int           n_strobe, n_abort;
        bits = '0;
        exp_bits = '0;
        oe_during = 1'b1;
        word = model_word(a, d, o);
        @(negedge clk);
        addr = a; data = d; osig = o;
        @(negedge clk);
        ss = 1'b0;
        repeat (8) @(negedge clk);
        if (n == 0) oe_during = oe;
        for (int i = 0; i < n; i++) begin
            if (i == change_at) addr = late_addr;
            sck_cycle((i < int'(ISIG_W)) ? mosi[i] : 1'($urandom_range(0, 1)), m);
            bits[i] = m;
            exp_bits[i] = (i < int'(TX_BITS)) ? word[i] : 1'b0;
            if (i == 0) oe_during = oe;
        end
        repeat (4) @(negedge clk);
        ss = 1'b1;
        n_strobe = 0;
        n_abort = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_strobe += int'(strobe);
            n_abort  += int'(abort_p);
        end
        if (n >= int'(ISIG_W)) model_isig = mosi;
        check({tag, "_miso"}, bits, exp_bits);
        check({tag, "_oe_active"}, 128'(oe_during), 128'd1);
        check({tag, "_strobe_cnt"}, 128'(n_strobe), (n >= int'(ISIG_W)) ? 128'd1 : 128'd0);
        check({tag, "_abort_cnt"}, 128'(n_abort), (n >= int'(ISIG_W)) ? 128'd0 : 128'd1);
        check({tag, "_isig"}, 128'(isig), 128'(model_isig));
        check({tag, "_oe_idle"}, {126'd0, oe, miso}, 128'd0);
    endtask

    initial begin
        logic m;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", {123'd0, strobe, abort_p, miso, oe, 1'b0}, 128'd0);
        check("reset_isig", 128'(isig), 128'd0);

        run_frame("basic", 24'h123456, 16'hBEEF, 8'hA5, 8'h3C, int'(TX_BITS), -1, '0);
        run_frame("abort5", 24'h123456, 16'hBEEF, 8'hA5, 8'hC3, 5, -1, '0);
        run_frame("overrun", 24'hABCDEF, 16'h1234, 8'h5A, 8'h81, int'(TX_BITS) + 8, -1, '0);
        run_frame("atomic", 24'h000001, 16'h0000, 8'h00, 8'h7E, int'(TX_BITS), 3, 24'hFFFFFF);
        run_frame("zero", '0, '0, '0, 8'h00, int'(TX_BITS), -1, '0);
        run_frame("exact_isig", 24'h000001, 16'h0000, 8'h00, 8'h96, int'(ISIG_W), -1, '0);
        run_frame("one_short", 24'hFFFFFF, 16'hFFFF, 8'hFF, 8'h11, int'(ISIG_W) - 1, -1, '0);

        // Reset in the middle of a frame discards it and clears INPUT_SIGNAL.
        @(negedge clk);
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 20; i++) sck_cycle(1'b1, m);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        model_isig = '0;
        check("midreset_isig", 128'(isig), 128'd0);
        check("midreset_miso_oe", {126'd0, miso, oe}, 128'd0);
        for (int i = 0; i < 4; i++) sck_cycle(1'b1, m);
        check("midreset_ignored_sck", {126'd0, miso, oe}, 128'd0);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        run_frame("after_reset", 24'h00C0DE, 16'hCAFE, 8'h3C, 8'h5A, int'(TX_BITS), -1, '0);

        for (int t = 0; t < 8; t++) begin
            run_frame("rand", ADDR_W'($urandom), DATA_W'($urandom), OSIG_W'($urandom), ISIG_W'($urandom),
                      int'($urandom_range(0, TX_BITS + 8)), -1, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
